// File: rtl/data_mem_pkg.sv
// data_mem_pkg -- shared processor definitions.
// Holds the ALU operation encodings, the data-memory access-size encodings
// (mem_op) and the default data-memory depth, plus small helpers used by
// the memory datapath.
package data_mem_pkg;

  localparam int DEPTH_WORDS_DEF = 64;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

  // Access size / sign for loads and stores. 101..111 are illegal.
  typedef enum logic [2:0] {
    MEM_W  = 3'b000,
    MEM_H  = 3'b001,
    MEM_HU = 3'b010,
    MEM_B  = 3'b011,
    MEM_BU = 3'b100
  } mem_op_e;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= 3'd4;
  endfunction

  function automatic logic op_is_half(input logic [2:0] op);
    return (op == MEM_H) || (op == MEM_HU);
  endfunction

  function automatic logic op_is_byte(input logic [2:0] op);
    return (op == MEM_B) || (op == MEM_BU);
  endfunction

endpackage

// File: rtl/data_mem_load_align.sv
// load_align -- combinational load formatter.
// Picks the byte/half/word addressed by off out of the fetched word and
// sign- or zero-extends it according to mem_op. Output is forced to zero
// when en is low (no read, or the request faulted).
//   word   : raw 32-bit word from the array
//   mem_op : access size/sign
//   off    : addr[1:0]
//   en     : load is active and legal
//   rdata  : formatted load result
module load_align
  import data_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  mem_op,
  input  logic [1:0]  off,
  input  logic        en,
  output logic [31:0] rdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = off[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    rdata = '0;
    if (en) begin
      case (mem_op)
        MEM_W:   rdata = word;
        MEM_H:   rdata = {{16{half_sel[15]}}, half_sel};
        MEM_HU:  rdata = {16'h0000, half_sel};
        MEM_B:   rdata = {{24{byte_sel[7]}}, byte_sel};
        MEM_BU:  rdata = {24'h000000, byte_sel};
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: rtl/data_mem.sv
// data_mem -- single-cycle byte-addressable data memory.
// Loads are combinational (read-before-write against a same-cycle store);
// stores commit on the rising edge, touching only the byte lanes selected
// by size and addr[1:0]. Misaligned, illegal-size or simultaneous
// read+write requests fault: nothing is written, rdata is 0.
//   clk, rst_n  : clock, synchronous active-low reset (clears the array)
//   mem_read    : load request
//   mem_write   : store request
//   mem_op      : access size/sign
//   addr        : byte address (upper bits beyond the array wrap)
//   wdata       : store data, low byte/half used for sb/sh
//   rdata       : formatted load data
//   misalign    : current request faults
//   err_sticky  : a fault has been seen since reset
//   store_count : committed stores, wraps at 16 bits
module data_mem
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        err_sticky,
  output logic [15:0] store_count
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic [31:0]   rd_word;
  logic [3:0]    lane_en;
  logic [31:0]   wlane;
  logic          commit;

  // Address bits above the array are deliberately dropped (aliasing).
  logic unused_addr;
  assign unused_addr = &{1'b0, addr[31:AW+2]};

  assign idx     = addr[AW+1:2];
  assign off     = addr[1:0];
  assign rd_word = mem[idx];

  always_comb begin
    misalign = 1'b0;
    if (mem_read || mem_write) begin
      if (!op_legal(mem_op))                   misalign = 1'b1;
      else if (op_is_half(mem_op) && off[0])   misalign = 1'b1;
      else if (mem_op == MEM_W && off != 2'b00) misalign = 1'b1;
      if (mem_read && mem_write)               misalign = 1'b1;
    end
  end

  // Replicate the store data across lanes so each enabled lane simply
  // takes its own slice.
  always_comb begin
    lane_en = 4'b0000;
    wlane   = wdata;
    if (op_is_byte(mem_op)) begin
      lane_en = 4'b0001 << off;
      wlane   = {4{wdata[7:0]}};
    end else if (op_is_half(mem_op)) begin
      lane_en = off[1] ? 4'b1100 : 4'b0011;
      wlane   = {2{wdata[15:0]}};
    end else if (mem_op == MEM_W) begin
      lane_en = 4'b1111;
    end
  end

  assign commit = mem_write && !misalign;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (commit) begin
      for (int b = 0; b < 4; b++)
        if (lane_en[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      store_count <= '0;
      err_sticky  <= 1'b0;
    end else begin
      if (commit)   store_count <= store_count + 16'd1;
      if (misalign) err_sticky  <= 1'b1;
    end
  end

  load_align u_load_align (
    .word   (rd_word),
    .mem_op (mem_op),
    .off    (off),
    .en     (mem_read && !misalign),
    .rdata  (rdata)
  );

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem -- directed self-checking bench for data_mem.
// Inputs change on the falling edge; combinational outputs are checked just
// after, registered outputs are checked after the next rising edge.
module tb_data_mem;
  import data_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [2:0]  mem_op;
  logic [31:0] addr, wdata, rdata;
  logic        misalign, err_sticky;
  logic [15:0] store_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_mem #(.DEPTH_WORDS(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_op      (mem_op),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .misalign    (misalign),
    .err_sticky  (err_sticky),
    .store_count (store_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rd, input logic wr,
                       input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    rst_n = r; mem_read = rd; mem_write = wr; mem_op = op; addr = a; wdata = d;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    mem_op = 3'b000; addr = '0; wdata = '0;

    // reset: combinational fault still reported, registers cleared
    drive(0, 0, 0, MEM_W, 32'h0, 32'h0);
    drive(0, 1, 0, MEM_W, 32'h12, 32'h0);
    chk("rst_misalign", misalign, 1);
    chk("rst_misalign_rdata", rdata, 0);
    drive(0, 0, 0, MEM_W, 32'h0, 32'h0);
    chk("rst_cnt", store_count, 0);
    chk("rst_err", err_sticky, 0);
    drive(0, 1, 0, MEM_W, 32'h10, 32'h0);
    chk("rst_rd", rdata, 0);
    chk("rst_rd_ok", misalign, 0);

    // sw / lw
    drive(1, 0, 1, MEM_W, 32'h10, 32'h8BADF00D);
    chk("sw_nofault", misalign, 0);
    chk("sw_rdata0", rdata, 0);
    drive(1, 1, 0, MEM_W, 32'h10, 32'h0);
    chk("lw_10", rdata, 32'h8BADF00D);
    chk("cnt_1", store_count, 1);

    // sub-word loads
    drive(1, 1, 0, MEM_B,  32'h13, 32'h0); chk("lb_13",  rdata, 32'hFFFFFF8B);
    drive(1, 1, 0, MEM_BU, 32'h13, 32'h0); chk("lbu_13", rdata, 32'h0000008B);
    drive(1, 1, 0, MEM_H,  32'h12, 32'h0); chk("lh_12",  rdata, 32'hFFFF8BAD);
    drive(1, 1, 0, MEM_HU, 32'h10, 32'h0); chk("lhu_10", rdata, 32'h0000F00D);
    drive(1, 1, 0, MEM_B,  32'h11, 32'h0); chk("lb_11",  rdata, 32'hFFFFFFF0);
    drive(1, 1, 0, MEM_H,  32'h10, 32'h0); chk("lh_10",  rdata, 32'hFFFFF00D);
    drive(1, 0, 0, MEM_W,  32'h10, 32'h0); chk("noread_0", rdata, 0);

    // sb only touches lane 1
    drive(1, 0, 1, MEM_B, 32'h11, 32'hFFFFFF5A);
    drive(1, 1, 0, MEM_W, 32'h10, 32'h0);
    chk("sb_lw_10", rdata, 32'h8BAD5A0D);
    chk("cnt_2", store_count, 2);
    drive(1, 1, 0, MEM_W, 32'h14, 32'h0);
    chk("lw_14_untouched", rdata, 0);

    // sh upper half
    drive(1, 0, 1, MEM_H, 32'h16, 32'hABCD1234);
    drive(1, 1, 0, MEM_HU, 32'h16, 32'h0);
    chk("lhu_16", rdata, 32'h00001234);
    chk("cnt_3", store_count, 3);
    drive(1, 1, 0, MEM_W, 32'h14, 32'h0);
    chk("sh_lw_14", rdata, 32'h12340000);
    chk("err_clean", err_sticky, 0);

    // misaligned sw
    drive(1, 0, 1, MEM_W, 32'h12, 32'hFFFFFFFF);
    chk("sw_12_misalign", misalign, 1);
    drive(1, 1, 0, MEM_W, 32'h10, 32'h0);
    chk("sw_12_nowrite", rdata, 32'h8BAD5A0D);
    chk("sw_12_cnt", store_count, 3);
    chk("sw_12_err", err_sticky, 1);

    // other faults
    drive(1, 1, 0, MEM_H, 32'h11, 32'h0);
    chk("lh_11_misalign", misalign, 1);
    chk("lh_11_rdata", rdata, 0);
    drive(1, 1, 0, 3'b101, 32'h10, 32'h0);
    chk("illegal_op", misalign, 1);
    chk("illegal_rdata", rdata, 0);
    drive(1, 0, 0, 3'b111, 32'h13, 32'h0);
    chk("idle_nofault", misalign, 0);
    drive(1, 1, 0, MEM_B, 32'h13, 32'h0);
    chk("lb_odd_ok", misalign, 0);

    // simultaneous read+write
    drive(1, 1, 1, MEM_W, 32'h20, 32'h11111111);
    chk("rw_fault", misalign, 1);
    chk("rw_rdata", rdata, 0);
    drive(1, 1, 0, MEM_W, 32'h20, 32'h0);
    chk("rw_nowrite", rdata, 0);
    chk("rw_cnt", store_count, 3);

    // store then load next cycle
    drive(1, 0, 1, MEM_W, 32'h20, 32'h11111111);
    drive(1, 1, 0, MEM_W, 32'h20, 32'h0);
    chk("sw_lw_20", rdata, 32'h11111111);
    chk("cnt_4", store_count, 4);

    // aliasing modulo 256 bytes
    drive(1, 0, 1, MEM_W, 32'h100, 32'hCAFEBABE);
    drive(1, 1, 0, MEM_W, 32'h000, 32'h0);
    chk("alias_0", rdata, 32'hCAFEBABE);
    chk("cnt_5", store_count, 5);
    drive(1, 1, 0, MEM_W, 32'h110, 32'h0);
    chk("alias_110", rdata, 32'h8BAD5A0D);

    // mid-sequence reset with a store presented: discarded
    drive(0, 0, 1, MEM_W, 32'h10, 32'hDEADBEEF);
    drive(1, 1, 0, MEM_W, 32'h10, 32'h0);
    chk("mrst_lw_10", rdata, 0);
    chk("mrst_cnt", store_count, 0);
    chk("mrst_err", err_sticky, 0);
    drive(1, 1, 0, MEM_W, 32'h00, 32'h0); chk("mrst_lw_00", rdata, 0);
    drive(1, 1, 0, MEM_W, 32'h20, 32'h0); chk("mrst_lw_20", rdata, 0);
    drive(1, 1, 0, MEM_W, 32'h14, 32'h0); chk("mrst_lw_14", rdata, 0);

    drive(1, 0, 1, MEM_W, 32'h08, 32'h00000055);
    drive(1, 1, 0, MEM_W, 32'h08, 32'h0);
    chk("post_rst_lw", rdata, 32'h55);
    chk("post_rst_cnt", store_count, 1);

    // store_count wrap
    for (int i = 0; i < 65534; i++) drive(1, 0, 1, MEM_W, 32'h08, i);
    drive(1, 0, 0, MEM_W, 32'h08, 32'h0);
    chk("cnt_ffff", store_count, 16'hFFFF);
    drive(1, 0, 1, MEM_W, 32'h08, 32'hA5A5A5A5);
    drive(1, 1, 0, MEM_W, 32'h08, 32'h0);
    chk("cnt_wrap", store_count, 0);
    chk("wrap_lw", rdata, 32'hA5A5A5A5);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, number of 32-bit words (power of two, 4..1024).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port mem_read  input  1  load request this cycle.
REQ-005 SHALL have port mem_write  input  1  store request this cycle.
REQ-006 SHALL have port mem_op  input  3  access size/sign: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; 101-111 illegal.
REQ-007 SHALL have port addr  input  32  byte address, driven by the ALU result (dataOut).
REQ-008 SHALL have port wdata  input  32  store data (rt); low byte/half used for sb/sh.
REQ-009 SHALL have port rdata  output  32  formatted load data, combinational.
REQ-010 SHALL have port misalign  output  1  combinational: current request faults.
REQ-011 SHALL have port err_sticky  output  1  registered: a fault has occurred since reset.
REQ-012 SHALL have port store_count  output  16  registered count of committed stores.

Function
REQ-013 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (wrap modulo 4*DEPTH_WORDS).
REQ-014 Fault = request active (mem_read|mem_write) and (mem_op illegal, or half with addr[0]=1, or word with addr[1:0]!=00).
REQ-015 Fault also when mem_read and mem_write are both 1 in the same cycle.
REQ-016 Store SHALL commit on the clock edge when mem_write=1, rst_n=1, no fault; only byte lanes selected by size and addr[1:0] change.
REQ-017 Lane mapping little-endian: byte n of word = bits [8n+7:8n]; half at addr[1]=0 -> [15:0], addr[1]=1 -> [31:16].
REQ-018 Faulting store SHALL NOT modify memory or store_count.
REQ-019 rdata SHALL be formatted from the addressed word the same cycle: byte/half selected by addr[1:0], sign- or zero-extended per mem_op.
REQ-020 rdata SHALL be 0 when mem_read=0 or fault.
REQ-021 Load of a word stored in the same cycle SHALL return the pre-store value (read-before-write); new value visible next cycle.
REQ-022 store_count SHALL increment by 1 per committed store, wrapping 0xFFFF -> 0x0000.
REQ-023 err_sticky SHALL set on the edge following any cycle with misalign=1 and hold until reset.
REQ-024 No operation SHALL take more than one cycle; no stall output exists.

Reset
REQ-025 While rst_n=0 at a clock edge: all memory words -> 0, store_count -> 0, err_sticky -> 0; stores in that cycle are discarded.
REQ-026 Combinational outputs (rdata, misalign) SHALL follow REQ-014..020 during reset; rdata reflects array contents as they stand.
REQ-027 Reset asserted mid-sequence SHALL leave no partial state; first post-reset store behaves as from power-up.

Structure
REQ-028 mem_op encodings and DEPTH_WORDS default SHALL live in the shared processor package alongside the ALUop encodings.
REQ-029 Load formatting (select + extend) SHALL be one combinational sub-module, load_align; store lane enables generated in data_mem.

Verification
REQ-030 sw 0x8BADF00D to addr 0x10, then lw 0x10 -> rdata=0x8BADF00D; store_count=1.
REQ-031 After REQ-030, lb 0x13 -> 0xFFFFFF8B; lbu 0x13 -> 0x0000008B; lh 0x12 -> 0xFFFF8BAD; lhu 0x10 -> 0x0000F00D.
REQ-032 sb 0x5A to addr 0x11 over 0x8BADF00D -> lw 0x10 = 0x8BAD5A0D; other words unchanged.
REQ-033 sw to 0x12 (misaligned) -> misalign=1 that cycle, memory unchanged, store_count unchanged, err_sticky=1 next cycle.
REQ-034 Same-cycle sw 0x11111111 and lw to 0x20 (mem_read=mem_write=1) -> fault, no write; separate same-address sw then lw next cycle returns new value; addr 0x100 (DEPTH 64) aliases 0x000.
REQ-035 Assert rst_n=0 for one edge after 3 stores -> all words read 0, store_count=0, err_sticky=0.
